// File: rtl/mar_burst_pkg.sv
// Shared widths and FSM state encoding for the burst-capable memory address register.
package mar_burst_pkg;

    localparam int unsigned OP_W_DEF    = 8;
    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned BURST_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mar_burst_counter.sv
// Remaining-beat counter for a burst: loaded with the beat count, decremented per accepted beat.
module mar_burst_counter
    import mar_burst_pkg::*;
#(
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [BURST_W-1:0] i_len,
    input  logic               i_dec,
    output logic [BURST_W-1:0] o_remaining,
    output logic               o_last_c
);

    logic [BURST_W-1:0] r_remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_len;
        end else if (i_dec) begin
            r_remaining <= r_remaining - BURST_W'(1);
        end
    end

    assign o_remaining = r_remaining;
    assign o_last_c    = (r_remaining == BURST_W'(1));

endmodule

// File: rtl/mar_burst.sv
// Memory address register with load/increment and an autonomous valid/ready burst generator.
module mar_burst
    import mar_burst_pkg::*;
#(
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_W+ADDR_W-1:0] i_bus_in,
    input  logic                   i_load,
    input  logic                   i_inc,
    input  logic                   i_burst_start,
    input  logic [BURST_W-1:0]     i_burst_len,
    input  logic                   i_mem_ready,
    output logic [ADDR_W-1:0]      o_address,
    output logic                   o_addr_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_wrap
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_address;
    logic [ADDR_W-1:0]   w_next_address;
    logic                r_addr_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_wrap;
    logic                w_next_wrap;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_cnt_last;
    logic [BURST_W-1:0]  w_cnt_remaining;
    logic [ADDR_W-1:0]   w_bus_addr;
    logic [ADDR_W-1:0]   w_addr_plus1;
    logic                w_addr_all_ones;
    logic                w_unused_op;

    assign w_bus_addr      = i_bus_in[ADDR_W-1:0];
    assign w_addr_plus1    = r_address + ADDR_W'(1);
    assign w_addr_all_ones = &r_address;
    // Opcode field belongs to the instruction decoder, not this block.
    assign w_unused_op     = ^{i_bus_in[OP_W+ADDR_W-1:ADDR_W], w_cnt_remaining};

    mar_burst_counter #(
        .BURST_W (BURST_W)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_cnt_load),
        .i_len       (i_burst_len),
        .i_dec       (w_cnt_dec),
        .o_remaining (w_cnt_remaining),
        .o_last_c    (w_cnt_last)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_address    <= '0;
            r_addr_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_address    <= w_next_address;
            r_addr_valid <= (w_next_state == ST_BURST);
            r_busy       <= (w_next_state != ST_IDLE);
            r_done       <= (w_next_state == ST_DONE);
            r_wrap       <= w_next_wrap;
        end
    end

    // Next state, next address and counter controls.
    always_comb begin
        w_next_state   = r_state;
        w_next_address = r_address;
        w_next_wrap    = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_dec      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_next_address = w_bus_addr;
                end else if (i_inc && !i_burst_start) begin
                    w_next_address = w_addr_plus1;
                    w_next_wrap    = w_addr_all_ones;
                end else if (i_inc && (i_burst_len == '0)) begin
                    w_next_address = w_addr_plus1;
                    w_next_wrap    = w_addr_all_ones;
                end
                if (i_burst_start && (i_burst_len != '0)) begin
                    w_next_state = ST_BURST;
                    w_cnt_load   = 1'b1;
                end
            end
            ST_BURST: begin
                if (i_mem_ready) begin
                    w_next_address = w_addr_plus1;
                    w_next_wrap    = w_addr_all_ones;
                    w_cnt_dec      = 1'b1;
                    if (w_cnt_last) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign o_address    = r_address;
    assign o_addr_valid = r_addr_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_wrap       = r_wrap;

endmodule
